execute_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the Execute stage. It is fed by the D->E pipeline register outputs plus the forwarded operands.
- Accepts one M-extension op, raises a stall request toward the hazard unit while computing, then presents the 32-bit result for one cycle so the E->M register can capture it.
- Uses one shared 32-iteration shift/add-subtract datapath with a fixed latency for all ops.

---
 rtl/execute_muldiv_unit_if.sv | 28 ++
 rtl/execute_muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_execute_muldiv_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_muldiv_unit_if.sv
// Execute-stage M-extension bus: issue fields from the D->E register and
// forwarding network toward the unit, and stall/result signals back out.
interface execute_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            iStartE;
  logic [2:0]      iFunct3E;
  logic [XLEN-1:0] iSrcAE;
  logic [XLEN-1:0] iSrcBE;
  logic [4:0]      iRdE;
  logic            iFlushE;
  logic            oBusyE;
  logic            oDoneE;
  logic [XLEN-1:0] oResultE;
  logic [4:0]      oRdE;

  // Pipeline side: issues ops and consumes the stall request and result
  modport master (
    output iStartE, iFunct3E, iSrcAE, iSrcBE, iRdE, iFlushE,
    input  oBusyE, oDoneE, oResultE, oRdE
  );

  // Unit side: the iterative multiply/divide engine
  modport slave (
    input  iStartE, iFunct3E, iSrcAE, iSrcBE, iRdE, iFlushE,
    output oBusyE, oDoneE, oResultE, oRdE
  );
endinterface

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// One shared hi/lo shift register pair serves both the shift-add multiplier
// and the restoring divider, so every op takes the same number of cycles:
// accept, ITER iterations, one sign-fix cycle, then a one-cycle done pulse.
module execute_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic                  iClk,
  input logic                  iRstN,
  execute_muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] hiReg;
  logic [XLEN-1:0] loReg;
  logic [XLEN-1:0] magB;
  logic [2:0]      opReg;
  logic            negRes;
  logic            negRem;
  logic            divZero;
  logic            divOvf;

  logic            aSigned;
  logic            bSigned;
  logic            inSignA;
  logic            inSignB;
  logic [XLEN-1:0] inMagA;
  logic [XLEN-1:0] inMagB;
  logic            inDivZero;
  logic            inOvf;

  logic [XLEN:0]   mulSum;
  logic [XLEN:0]   divShift;
  logic [XLEN:0]   divDiff;

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quoFix;
  logic [XLEN-1:0]   remFix;
  logic [XLEN-1:0]   fixResult;

  // Decode operand signedness and magnitudes from the issue fields; only used on the accept edge
  always_comb begin
    aSigned = 1'b0;
    bSigned = 1'b0;
    case (bus.iFunct3E)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        aSigned = 1'b1;
        bSigned = 1'b1;
      end
      3'b010: aSigned = 1'b1;
      default: ;
    endcase
    inSignA   = aSigned & bus.iSrcAE[XLEN-1];
    inSignB   = bSigned & bus.iSrcBE[XLEN-1];
    inMagA    = inSignA ? -bus.iSrcAE : bus.iSrcAE;
    inMagB    = inSignB ? -bus.iSrcBE : bus.iSrcBE;
    inDivZero = (bus.iSrcBE == '0);
    inOvf     = aSigned & bus.iFunct3E[2]
              & (bus.iSrcAE == {1'b1, {(XLEN-1){1'b0}}})
              & (bus.iSrcBE == '1);
  end

  // One iteration step of each algorithm on the shared hi/lo registers
  always_comb begin
    mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, magB} : '0);
    divShift = {hiReg, loReg[XLEN-1]};
    divDiff  = divShift - {1'b0, magB};
  end

  // Sign correction, half selection and RISC-V special cases applied in FIX.
  // A zero divisor leaves the dividend magnitude in hiReg, so REM/REMU by
  // zero naturally return A once the remainder sign (sign of A) is restored.
  always_comb begin
    prod    = {hiReg, loReg};
    prodFix = negRes ? -prod : prod;
    quoFix  = negRes ? -loReg : loReg;
    remFix  = negRem ? -hiReg : hiReg;
    case (opReg)
      3'b000:                 fixResult = prodFix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fixResult = prodFix[2*XLEN-1:XLEN];
      3'b100: begin
        if (divZero)     fixResult = '1;
        else if (divOvf) fixResult = {1'b1, {(XLEN-1){1'b0}}};
        else             fixResult = quoFix;
      end
      3'b101:                 fixResult = divZero ? '1 : quoFix;
      3'b110:                 fixResult = divOvf ? '0 : remFix;
      default:                fixResult = remFix;
    endcase
  end

  // Stall covers the issue cycle combinationally, then the whole CALC/FIX window
  assign bus.oBusyE = iRstN & ((state == IDLE & bus.iStartE & ~bus.iFlushE)
                               | state == CALC | state == FIX);

  // Control FSM with the shared datapath registers and registered outputs
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state        <= IDLE;
      count        <= '0;
      hiReg        <= '0;
      loReg        <= '0;
      magB         <= '0;
      opReg        <= '0;
      negRes       <= 1'b0;
      negRem       <= 1'b0;
      divZero      <= 1'b0;
      divOvf       <= 1'b0;
      bus.oResultE <= '0;
      bus.oDoneE   <= 1'b0;
      bus.oRdE     <= '0;
    end else begin
      bus.oDoneE <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStartE && !bus.iFlushE) begin
            hiReg    <= '0;
            loReg    <= inMagA;
            magB     <= inMagB;
            opReg    <= bus.iFunct3E;
            negRes   <= inSignA ^ inSignB;
            negRem   <= inSignA;
            divZero  <= inDivZero;
            divOvf   <= inOvf;
            bus.oRdE <= bus.iRdE;
            count    <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (bus.iFlushE) begin
            state <= IDLE;
          end else begin
            if (opReg[2]) begin
              if (!divDiff[XLEN]) begin
                hiReg <= divDiff[XLEN-1:0];
                loReg <= {loReg[XLEN-2:0], 1'b1};
              end else begin
                hiReg <= divShift[XLEN-1:0];
                loReg <= {loReg[XLEN-2:0], 1'b0};
              end
            end else begin
              hiReg <= mulSum[XLEN:1];
              loReg <= {mulSum[0], loReg[XLEN-1:1]};
            end
            if (count == CW'(ITER - 1)) begin
              state <= FIX;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        FIX: begin
          if (bus.iFlushE) begin
            state <= IDLE;
          end else begin
            bus.oResultE <= fixResult;
            bus.oDoneE   <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: directed RV32M cases with
// literal answers, flush/reset scenarios and randomized ops, all compared
// every cycle against an arithmetic reference model.
module tb_execute_muldiv_unit;

  logic iClk  = 1'b0;
  logic iRstN = 1'b1;

  execute_muldiv_unit_if #(.XLEN(32)) bus();

  execute_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus)
  );

  int passCount  = 0;
  int checkCount = 0;

  // Model state: is an op in flight, edges since accept, expected and shown result
  bit          mActive = 1'b0;
  int          mK      = 0;
  logic [31:0] mExpRes = '0;
  logic [31:0] mRes    = '0;
  logic [4:0]  mRd     = '0;

  // Free-running clock, 10 time-unit period
  always #5 iClk = ~iClk;

  // RV32M result straight from the ISA rules using wide arithmetic
  function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  // One comparison: counts it, reports a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model advanced on each edge: an op takes 33 edges from accept to done
  always @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      mActive <= 1'b0;
      mK      <= 0;
      mExpRes <= '0;
      mRes    <= '0;
      mRd     <= '0;
    end else if (mActive) begin
      if (mK <= 32 && bus.iFlushE) begin
        mActive <= 1'b0;
      end else if (mK == 33) begin
        mActive <= 1'b0;
      end else begin
        if (mK == 32) mRes <= mExpRes;
        mK <= mK + 1;
      end
    end else if (bus.iStartE && !bus.iFlushE) begin
      mActive <= 1'b1;
      mK      <= 0;
      mExpRes <= refResult(bus.iFunct3E, bus.iSrcAE, bus.iSrcBE);
      mRd     <= bus.iRdE;
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge
  always @(negedge iClk) begin
    logic expBusy;
    logic expDone;
    expBusy = iRstN && ((mActive && mK <= 32) || (!mActive && bus.iStartE && !bus.iFlushE));
    expDone = mActive && mK == 33;
    checkOutput("cyc_busy",   32'(bus.oBusyE), 32'(expBusy));
    checkOutput("cyc_done",   32'(bus.oDoneE), 32'(expDone));
    checkOutput("cyc_result", bus.oResultE, mRes);
    checkOutput("cyc_rd",     32'(bus.oRdE), 32'(mRd));
  end

  // Issue one op, optionally disturb inputs while it runs, then check latency and result
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expRes,
                               input string name, input bit noise, input bit flushInDone);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    bus.iStartE  = 1'b1;
    bus.iFunct3E = f;
    bus.iSrcAE   = a;
    bus.iSrcBE   = b;
    bus.iRdE     = rd;
    @(posedge iClk); #1;
    bus.iStartE = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge iClk); #1;
      if (bus.oDoneE) begin
        n    = i;
        seen = 1'b1;
        break;
      end
      if (noise) begin
        bus.iStartE  = 1'($urandom_range(0, 1));
        bus.iFunct3E = 3'($urandom);
        bus.iSrcAE   = $urandom;
        bus.iSrcBE   = $urandom;
        bus.iRdE     = 5'($urandom);
      end
    end
    bus.iStartE = 1'b0;
    if (!seen) begin
      checkCount++;
      $display("[TB] FAIL %s_timeout: no done within 40 edges, expected 33", name);
    end else begin
      checkOutput({name, "_latency"}, 32'(n), 32'd33);
      checkOutput({name, "_result"}, bus.oResultE, expRes);
      checkOutput({name, "_rd"}, 32'(bus.oRdE), 32'(rd));
    end
    if (flushInDone) bus.iFlushE = 1'b1;
    @(posedge iClk); #1;
    bus.iFlushE = 1'b0;
  endtask

  // Watch a window of cycles and require that no done pulse appears
  task automatic expectNoDone(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge iClk); #1;
      if (bus.oDoneE) seen = 1'b1;
    end
    checkOutput(name, 32'(seen), 32'd0);
  endtask

  // Operand picker biased toward the interesting corner values
  function automatic logic [31:0] pickOperand();
    logic [31:0] corners [5];
    corners[0] = 32'h00000000;
    corners[1] = 32'h00000001;
    corners[2] = 32'hFFFFFFFF;
    corners[3] = 32'h80000000;
    corners[4] = 32'h7FFFFFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Bound the whole run so a stuck design still ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, model pins, directed cases, flush, reset, random
  initial begin
    bus.iStartE  = 1'b0;
    bus.iFunct3E = 3'd0;
    bus.iSrcAE   = '0;
    bus.iSrcBE   = '0;
    bus.iRdE     = '0;
    bus.iFlushE  = 1'b0;
    #2 iRstN = 1'b0;
    bus.iStartE = 1'b1;
    #1;
    checkOutput("reset_busy_gated", 32'(bus.oBusyE), 32'd0);
    bus.iStartE = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    checkOutput("reset_result", bus.oResultE, 32'd0);
    checkOutput("reset_done", 32'(bus.oDoneE), 32'd0);
    checkOutput("reset_rd", 32'(bus.oRdE), 32'd0);
    iRstN = 1'b1;

    checkOutput("pin_mul",    refResult(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    checkOutput("pin_mulhsu", refResult(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
    checkOutput("pin_div",    refResult(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    checkOutput("pin_rem",    refResult(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

    applyStimulus(3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, "mul",     1'b0, 1'b0);
    applyStimulus(3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, "mulh",    1'b0, 1'b0);
    applyStimulus(3'd3, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, "mulhu",   1'b0, 1'b0);
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, "mulhsu",  1'b0, 1'b0);
    applyStimulus(3'd5, 32'd100,      32'd7,        5'd5,  32'd14,       "divu",    1'b0, 1'b0);
    applyStimulus(3'd7, 32'd100,      32'd7,        5'd6,  32'd2,        "remu",    1'b0, 1'b0);
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, "div",     1'b0, 1'b0);
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, "rem",     1'b0, 1'b0);
    applyStimulus(3'd4, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, "div0",    1'b0, 1'b0);
    applyStimulus(3'd6, 32'd5,        32'd0,        5'd10, 32'd5,        "rem0",    1'b0, 1'b0);
    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, "divovf",  1'b0, 1'b0);
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        "removf",  1'b0, 1'b1);

    // Flush ten edges after accept: unit must drop busy and never pulse done
    bus.iStartE  = 1'b1;
    bus.iFunct3E = 3'd0;
    bus.iSrcAE   = 32'd9;
    bus.iSrcBE   = 32'd9;
    bus.iRdE     = 5'd20;
    @(posedge iClk); #1;
    bus.iStartE = 1'b0;
    repeat (9) @(posedge iClk);
    #1 bus.iFlushE = 1'b1;
    @(posedge iClk); #1;
    bus.iFlushE = 1'b0;
    checkOutput("flush_busy", 32'(bus.oBusyE), 32'd0);
    expectNoDone("flush_no_done", 40);
    applyStimulus(3'd5, 32'd1000, 32'd10, 5'd21, 32'd100, "post_flush", 1'b0, 1'b0);

    // Async reset five edges into CALC: outputs clear at once, nothing completes later
    bus.iStartE  = 1'b1;
    bus.iFunct3E = 3'd0;
    bus.iSrcAE   = 32'd11;
    bus.iSrcBE   = 32'd13;
    bus.iRdE     = 5'd22;
    @(posedge iClk); #1;
    bus.iStartE = 1'b0;
    repeat (5) @(posedge iClk);
    #1 iRstN = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(bus.oBusyE), 32'd0);
    checkOutput("arst_result", bus.oResultE, 32'd0);
    checkOutput("arst_rd", 32'(bus.oRdE), 32'd0);
    repeat (3) @(posedge iClk);
    #1 iRstN = 1'b1;
    expectNoDone("arst_no_done", 40);

    // Back-to-back multiplies with distinct destinations
    applyStimulus(3'd0, 32'd3, 32'd4, 5'd13, 32'd12, "b2b_first",  1'b0, 1'b0);
    applyStimulus(3'd0, 32'd5, 32'd6, 5'd14, 32'd30, "b2b_second", 1'b0, 1'b0);

    // Randomized ops with input noise while busy, occasional flush during the done cycle
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f  = 3'($urandom);
      a  = pickOperand();
      b  = pickOperand();
      rd = 5'($urandom);
      applyStimulus(f, a, b, rd, refResult(f, a, b), "rand", 1'b1, (i % 5) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
